// File: rtl/updown_sweep_controller.sv
// Sweep sequencer for the up/down counter datapath.
// Drives a WIDTH-bit count between latched low/high bounds. The sweep is either
// single up, single down, continuous ping-pong, or ping-pong for a fixed number of passes.
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   reset_i   synchronous active-high reset
//   start_i   launch request, honoured only while idle
//   mode_i    00 single up, 01 single down, 10 ping-pong, 11 N-pass ping-pong
//   low_i     lower bound, latched on an accepted start
//   high_i    upper bound, latched on an accepted start
//   passes_i  pass count for mode 11 (0 behaves as 1), latched on an accepted start
//   abort_i   terminates an active sweep without Done
//   count_o   current count (registered)
//   ud_o      current direction, 0 up / 1 down (registered)
//   busy_o    high while a sweep is active
//   done_o    one-cycle pulse on normal completion
//   err_o     one-cycle pulse when a start is rejected (low > high)
module updown_sweep_controller #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [WIDTH-1:0]  low_i,
  input  logic [WIDTH-1:0]  high_i,
  input  logic [PASS_W-1:0] passes_i,
  input  logic              abort_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              ud_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                ud_q, ud_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    low_q, low_d;
  logic [WIDTH-1:0]    high_q, high_d;
  logic [1:0]          mode_q, mode_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;

  logic [PASS_W-1:0]   pass_inc;
  logic                finish;
  logic                at_bound;

  assign pass_inc = pass_cnt_q + 1'b1;

  // Single sweeps and degenerate bounds always end at the first boundary; mode 11
  // ends once the pass being completed is the last requested one.
  assign finish = !mode_q[1] || (low_q == high_q) ||
                  ((mode_q == 2'b11) && (pass_inc == passes_q));

  assign at_bound = (state_q == StUp) ? (count_q == high_q) : (count_q == low_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ud_d       = ud_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    low_d      = low_q;
    high_d     = high_q;
    mode_d     = mode_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (low_i > high_i) begin
            err_d = 1'b1;
          end else begin
            low_d      = low_i;
            high_d     = high_i;
            mode_d     = mode_i;
            passes_d   = (passes_i == '0) ? PASS_W'(1) : passes_i;
            pass_cnt_d = '0;
            busy_d     = 1'b1;
            if (mode_i == 2'b01) begin
              count_d = high_i;
              ud_d    = 1'b1;
              state_d = StDown;
            end else begin
              count_d = low_i;
              ud_d    = 1'b0;
              state_d = StUp;
            end
          end
        end
      end

      StUp, StDown: begin
        if (abort_i) begin
          // Abort beats a same-edge boundary action; count and direction freeze.
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (at_bound) begin
          if (mode_q == 2'b11) begin
            pass_cnt_d = pass_inc;
          end
          if (finish) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (state_q == StUp) begin
            // Reverse with no dwell: leave the boundary on the same edge.
            count_d = count_q - 1'b1;
            ud_d    = 1'b1;
            state_d = StDown;
          end else begin
            count_d = count_q + 1'b1;
            ud_d    = 1'b0;
            state_d = StUp;
          end
        end else if (state_q == StUp) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ud_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      low_q      <= '0;
      high_q     <= '0;
      mode_q     <= 2'b00;
      passes_q   <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ud_q       <= ud_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      low_q      <= low_d;
      high_q     <= high_d;
      mode_q     <= mode_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign count_o = count_q;
  assign ud_o    = ud_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: each clock edge gets an expected
// {count, ud, busy, done, err} pushed before the edge and compared on the
// following falling edge.
module tb_updown_sweep_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [3:0] low;
  logic [3:0] high;
  logic [3:0] passes;
  logic       abort;
  logic [3:0] count;
  logic       ud;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [7:0] exp_cur;
  string      tag_cur;

  updown_sweep_controller #(
    .WIDTH (4),
    .PASS_W(4)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .mode_i  (mode),
    .low_i   (low),
    .high_i  (high),
    .passes_i(passes),
    .abort_i (abort),
    .count_o (count),
    .ud_o    (ud),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {cnt,ud,busy,done,err}=%h_%b%b%b%b expected %h_%b%b%b%b", tag,
               got[7:4], got[3], got[2], got[1], got[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Pushes the expectation for the coming edge, then advances past it.
  task automatic tick(input logic [3:0] c, input logic u, input logic b, input logic d,
                      input logic e, input string tag);
    exp_q.push_back({c, u, b, d, e});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
      tag_cur = tag_q.pop_front();
      check_eq(tag_cur, {count, ud, busy, done, err}, exp_cur);
    end
  end

  task automatic launch(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                        input logic [3:0] p);
    start  = 1'b1;
    mode   = m;
    low    = l;
    high   = h;
    passes = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [3:0] pp_cnt;
    logic       pp_ud;

    reset = 1'b1; start = 1'b0; mode = 2'b00; low = '0; high = '0; passes = '0; abort = 1'b0;
    tick(4'd0, 0, 0, 0, 0, "reset0");
    tick(4'd0, 0, 0, 0, 0, "reset1");
    reset = 1'b0;
    tick(4'd0, 0, 0, 0, 0, "idle");

    // Reset in the middle of a ping-pong sweep.
    launch(2'b10, 4'd2, 4'd9, 4'd0);
    tick(4'd2, 0, 1, 0, 0, "rstmid_acc");
    start = 1'b0;
    for (int c = 3; c <= 6; c++) tick(4'(c), 0, 1, 0, 0, $sformatf("rstmid_up%0d", c));
    reset = 1'b1;
    tick(4'd0, 0, 0, 0, 0, "rstmid_reset");
    reset = 1'b0;
    tick(4'd0, 0, 0, 0, 0, "rstmid_idle");

    // Single up, start held through the sweep.
    launch(2'b00, 4'd2, 4'd5, 4'd0);
    tick(4'd2, 0, 1, 0, 0, "m00_acc");
    for (int c = 3; c <= 5; c++) tick(4'(c), 0, 1, 0, 0, $sformatf("m00_up%0d", c));
    tick(4'd5, 0, 0, 1, 0, "m00_done");
    start = 1'b0;
    tick(4'd5, 0, 0, 0, 0, "m00_hold");

    // Two-pass ping-pong.
    launch(2'b11, 4'd1, 4'd3, 4'd2);
    tick(4'd1, 0, 1, 0, 0, "m11_acc");
    start = 1'b0;
    tick(4'd2, 0, 1, 0, 0, "m11_a");
    tick(4'd3, 0, 1, 0, 0, "m11_b");
    tick(4'd2, 1, 1, 0, 0, "m11_c");
    tick(4'd1, 1, 1, 0, 0, "m11_d");
    tick(4'd1, 1, 0, 1, 0, "m11_done");
    tick(4'd1, 1, 0, 0, 0, "m11_hold");

    // Full-range continuous ping-pong, then abort.
    launch(2'b10, 4'd0, 4'd15, 4'd0);
    pp_cnt = '0;
    pp_ud  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      p      = k % 30;
      pp_cnt = (p <= 15) ? 4'(p) : 4'(30 - p);
      pp_ud  = (p > 15) || (p == 0 && k > 0);
      tick(pp_cnt, pp_ud, 1, 0, 0, $sformatf("m10_k%0d", k));
      start = 1'b0;
    end
    abort = 1'b1;
    tick(pp_cnt, pp_ud, 0, 0, 0, "m10_abort");
    abort = 1'b0;
    tick(pp_cnt, pp_ud, 0, 0, 0, "m10_frozen0");
    tick(pp_cnt, pp_ud, 0, 0, 0, "m10_frozen1");

    // Rejected start, then degenerate single down.
    launch(2'b00, 4'd7, 4'd3, 4'd0);
    tick(pp_cnt, pp_ud, 0, 0, 1, "err_pulse");
    start = 1'b0;
    tick(pp_cnt, pp_ud, 0, 0, 0, "err_clear");
    launch(2'b01, 4'd4, 4'd4, 4'd0);
    tick(4'd4, 1, 1, 0, 0, "deg01_acc");
    start = 1'b0;
    tick(4'd4, 1, 0, 1, 0, "deg01_done");
    tick(4'd4, 1, 0, 0, 0, "deg01_hold");

    // Single down with high changed mid-sweep.
    launch(2'b01, 4'd0, 4'd3, 4'd0);
    tick(4'd3, 1, 1, 0, 0, "m01_acc");
    start = 1'b0;
    high  = 4'd9;
    for (int c = 2; c >= 0; c--) tick(4'(c), 1, 1, 0, 0, $sformatf("m01_dn%0d", c));
    tick(4'd0, 1, 0, 1, 0, "m01_done");
    tick(4'd0, 1, 0, 0, 0, "m01_hold");

    // Same sweep, abort on the boundary edge.
    launch(2'b01, 4'd0, 4'd3, 4'd0);
    tick(4'd3, 1, 1, 0, 0, "ab_acc");
    start = 1'b0;
    for (int c = 2; c >= 0; c--) tick(4'(c), 1, 1, 0, 0, $sformatf("ab_dn%0d", c));
    abort = 1'b1;
    tick(4'd0, 1, 0, 0, 0, "ab_bound");
    abort = 1'b0;
    tick(4'd0, 1, 0, 0, 0, "ab_nodone");

    // Abort while idle does not block a start.
    launch(2'b00, 4'd14, 4'd15, 4'd0);
    abort = 1'b1;
    tick(4'd14, 0, 1, 0, 0, "idleab_acc");
    start = 1'b0;
    abort = 1'b0;
    tick(4'd15, 0, 1, 0, 0, "idleab_up");
    tick(4'd15, 0, 0, 1, 0, "idleab_done");

    // Mode 11 with passes=0 behaves as one pass.
    launch(2'b11, 4'd5, 4'd7, 4'd0);
    tick(4'd5, 0, 1, 0, 0, "p0_acc");
    start = 1'b0;
    tick(4'd6, 0, 1, 0, 0, "p0_a");
    tick(4'd7, 0, 1, 0, 0, "p0_b");
    tick(4'd7, 0, 0, 1, 0, "p0_done");

    // Degenerate ping-pong still completes.
    launch(2'b10, 4'd8, 4'd8, 4'd0);
    tick(4'd8, 0, 1, 0, 0, "deg10_acc");
    start = 1'b0;
    tick(4'd8, 0, 0, 1, 0, "deg10_done");

    // Full-range single up, no wrap at the top.
    launch(2'b00, 4'd0, 4'd15, 4'd0);
    for (int c = 0; c <= 15; c++) begin
      tick(4'(c), 0, 1, 0, 0, $sformatf("full_up%0d", c));
      start = 1'b0;
    end
    tick(4'd15, 0, 0, 1, 0, "full_done");
    tick(4'd15, 0, 0, 0, 0, "full_hold");

    repeat (2) @(negedge clk);
    #1;
    check_eq("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
